seg7_scan: RTL and testbench
============================

# seg7_scan

Time-multiplexed scan driver for a multi-digit common-bus 7-segment display. It holds a DIGITS-nibble value and steps through the digits one at a time. For each digit it presents the nibble on `D` together with `enable`, which feeds the downstream hex-to-segment decoder, and drives a one-hot digit select.
- New values are double-buffered and applied only at frame boundaries, so the display never tears.
- A dead-time phase at the start of every digit slot suppresses ghosting.

## Interface
- `DIGITS`, 4: number of digits; legal range 2–8.
- `PRESCALE`, 1000: clk cycles per digit slot (P).
- `DEAD`, 16: blanked cycles at the start of each slot. Requires `0 <= DEAD < PRESCALE`; violation is an elaboration error.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `value`  in  4*DIGITS  display value; `value[3:0]` is digit 0, the least significant.
- `load`  in  1  single-cycle strobe; captures `value` into the shadow register.
- `pending`  out  1  shadow holds a value not yet applied.
- `frame`  out  1  one-cycle pulse on the first cycle of each new frame.
- `D`  out  4  nibble for the current digit, to the decoder.
- `enable`  out  1  decoder enable; 0 blanks the segments.
- `digit_sel`  out  DIGITS  one-hot digit select, active high; all zero when blanked.

## Operation
- Slot counter `cnt` runs 0..P-1. Digit index `idx` runs 0..DIGITS-1 and advances when `cnt` wraps. A frame is DIGITS slots.
- Two-state FSM per slot:
  - DEAD: `cnt < DEAD`; `enable=0`, `digit_sel=0`.
  - ON: `cnt >= DEAD`; `enable=1`, `digit_sel[idx]=1`.
  - DEAD→ON when `cnt == DEAD-1`, or immediately when `DEAD == 0`.
  - ON→DEAD when `cnt == P-1`, if `DEAD > 0`.
- `D` holds `active[4*idx +: 4]` for the whole slot, including the DEAD phase.
- Load path:
  - `load=1` writes `value` into `shadow` and sets `pending`.
  - Repeated loads before a boundary overwrite `shadow`; the last load wins.
- Frame boundary (`idx` wraps DIGITS-1→0):
  - If `pending`, then `active <= shadow` and `pending` clears.
  - If `load` is high in that same cycle, `value` bypasses the shadow: `active <= value` and `pending` stays 0.
- Reset mid-frame:
  - All state returns to reset values on the next edge.
  - `active`, `shadow` and any pending value are discarded.
  - Scanning restarts at slot 0, DEAD phase.
- Reset values: `cnt=0`, `idx=0`, FSM=DEAD, `active=0`, `shadow=0`, `pending=0`, `frame=0`, `enable=0`, `digit_sel=0`, `D=0`.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Cycle 0 is the first cycle with `reset=0`; it is cycle 0 of slot 0, frame 0.
- Slot k of a frame: `enable=1` on frame-relative cycles k·P+DEAD through k·P+P-1; otherwise 0.
- `D` changes on cycle k·P and is stable for P cycles.
- `frame` is high on cycles n·DIGITS·P for n ≥ 1. It does not pulse out of reset.
- Load latency:
  - A `load` on cycle t appears on `D` from the first boundary at or after t+1.
  - A load coinciding with a boundary cycle is applied at that boundary.
- `pending` rises the cycle after `load`. It falls on the cycle the `frame` pulse is observed.

## Configuration
- `SEG7_SCAN_LZB_EN` (leading-zero blanking).
  - Defined:
    - A digit k > 0 whose nibble and all more-significant nibbles of `active` are zero keeps `enable=0` and `digit_sel=0` for its entire slot.
    - Digit 0 is never blanked.
    - Slot timing and `D` are unchanged.
  - Undefined: every digit displays, including leading zeros.

## Structure
- Package `seg7_scan_pkg` holds:
  - FSM state typedef {DEAD, ON}.
  - Default constants `SEG7_DIGITS_DEF`, `SEG7_PRESCALE_DEF`, `SEG7_DEAD_DEF`.
- Sub-module `scan_tick`: parameterised modulo-P counter. It outputs `cnt` and a `wrap` pulse and uses the same synchronous reset.
- Top level holds the digit index, FSM, shadow/active registers and optional blanking logic.

## Test plan
All scenarios use P=8, DEAD=2, DIGITS=4.
- Reset release:
  - Cycles 0–1: `enable=0`, `digit_sel=0`, `D=0`.
  - Cycles 2–7: `enable=1`, `digit_sel=4'b0001`.
  - Cycle 8: `digit_sel=0`, then `4'b0010` from cycle 10.
  - First `frame` pulse at cycle 32.
- `load` of 16'h1234 at cycle 5:
  - `pending=1` over cycles 6–31, `D=0` through cycle 31.
  - Cycles 32–63: `D` = 4, 3, 2, 1 per slot; `pending=0` from cycle 32.
- Loads of 16'hAAAA at cycle 10 and 16'h5555 at cycle 20: frame starting at cycle 32 shows all 5s. 16'hAAAA never appears.
- `load` of 16'hBEEF exactly on boundary cycle 31: `D=F` at cycle 32; `pending` never asserts.
- `reset` asserted at cycle 45 after 16'h1234 is active:
  - Next cycle all outputs are at reset values.
  - Frame restarts; `D=0` until a new load.
- With `SEG7_SCAN_LZB_EN` and `active`=16'h0050:
  - Slots 2 and 3: `enable=0` throughout.
  - Slot 1: `D=5`, enabled.
  - Slot 0: `D=0`, enabled.
  - Same value with the macro undefined: all four slots enabled.

Source files
------------

// File: rtl/seg7_scan_pkg.sv
// seg7_scan_pkg: shared types and default constants for the seg7_scan
// multiplexed 7-segment scan driver.
//   scan_state_e      : per-slot phase (blanked dead-time, or lit)
//   SEG7_DIGITS_DEF   : default number of digits
//   SEG7_PRESCALE_DEF : default clk cycles per digit slot
//   SEG7_DEAD_DEF     : default blanked cycles at the start of each slot
package seg7_scan_pkg;

    typedef enum logic {
        S_DEAD = 1'b0,
        S_ON   = 1'b1
    } scan_state_e;

    localparam int SEG7_DIGITS_DEF   = 4;
    localparam int SEG7_PRESCALE_DEF = 1000;
    localparam int SEG7_DEAD_DEF     = 16;

endpackage

// File: rtl/seg7_scan_tick.sv
// scan_tick: free-running modulo-PRESCALE counter that paces digit slots.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous active-high reset, returns cnt to 0
//   cnt   : current position within the slot, 0..PRESCALE-1
//   wrap  : high on the last cycle of a slot (cnt == PRESCALE-1)
module scan_tick #(
    parameter int PRESCALE = 1000,
    parameter int CNT_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1
) (
    input  logic             clk,
    input  logic             reset,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

    assign wrap = (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (wrap) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seg7_scan.sv
// seg7_scan: time-multiplexed scan driver for a common-bus 7-segment display.
// Steps through DIGITS nibbles, one slot of PRESCALE cycles per digit, with
// DEAD blanked cycles at the start of each slot. New values are held in a
// shadow register and only copied to the displayed register at frame
// boundaries so a frame never mixes two values.
// Optional feature: define SEG7_SCAN_LZB_EN for leading-zero blanking.
// Ports:
//   clk       : system clock, rising edge
//   reset     : synchronous active-high reset
//   value     : display value, value[3:0] is digit 0 (least significant)
//   load      : single-cycle strobe capturing value
//   pending   : shadow holds a value not yet displayed
//   frame     : one-cycle pulse on the first cycle of each new frame
//   D         : nibble of the current digit, to the hex decoder
//   enable    : decoder enable, 0 blanks the segments
//   digit_sel : one-hot digit select, all zero while blanked
module seg7_scan
    import seg7_scan_pkg::*;
#(
    parameter int DIGITS   = SEG7_DIGITS_DEF,
    parameter int PRESCALE = SEG7_PRESCALE_DEF,
    parameter int DEAD     = SEG7_DEAD_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [4*DIGITS-1:0] value,
    input  logic                load,
    output logic                pending,
    output logic                frame,
    output logic [3:0]          D,
    output logic                enable,
    output logic [DIGITS-1:0]   digit_sel
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IDX_W = $clog2(DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DIGITS - 1);
    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'((DEAD > 0) ? DEAD - 1 : 0);

    if (DIGITS < 2 || DIGITS > 8) begin : g_bad_digits
        $error("seg7_scan: DIGITS must be within 2..8");
    end
    if (DEAD < 0 || DEAD >= PRESCALE) begin : g_bad_dead
        $error("seg7_scan: DEAD must satisfy 0 <= DEAD < PRESCALE");
    end

    logic [CNT_W-1:0]    cnt;
    logic                wrap;
    logic [IDX_W-1:0]    idx, idx_next;
    scan_state_e         state, state_next;
    logic [4*DIGITS-1:0] active, active_next;
    logic [4*DIGITS-1:0] shadow, shadow_next;
    logic                pending_next;
    logic                boundary;
    logic                blank;
    logic [3:0]          d_next;
    logic                en_next;
    logic [DIGITS-1:0]   sel_next;

    scan_tick #(
        .PRESCALE (PRESCALE),
        .CNT_W    (CNT_W)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .cnt   (cnt),
        .wrap  (wrap)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_DEAD;
        end else begin
            state <= state_next;
        end
    end

    // Outputs are registered from next-cycle values, so every output lines
    // up with the cnt/idx of the cycle it is observed in.
    always_comb begin
        state_next = state;
        if (DEAD == 0) begin
            state_next = S_ON;
        end else begin
            case (state)
                S_DEAD:  if (cnt == DEAD_LAST) state_next = S_ON;
                S_ON:    if (wrap) state_next = S_DEAD;
                default: state_next = S_DEAD;
            endcase
        end

        idx_next = idx;
        if (wrap) begin
            idx_next = (idx == LAST_IDX) ? '0 : idx + 1'b1;
        end
        boundary = wrap && (idx == LAST_IDX);

        active_next  = active;
        shadow_next  = shadow;
        pending_next = pending;
        if (load) begin
            shadow_next = value;
        end
        if (boundary) begin
            // A load landing on the boundary goes straight to the display.
            if (load) begin
                active_next = value;
            end else if (pending) begin
                active_next = shadow;
            end
            pending_next = 1'b0;
        end else if (load) begin
            pending_next = 1'b1;
        end

        d_next = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_next == IDX_W'(k)) d_next = active_next[4*k +: 4];
        end

`ifdef SEG7_SCAN_LZB_EN
        // Digit k is a leading zero when it and everything above it is zero.
        blank = 1'b0;
        for (int k = 1; k < DIGITS; k++) begin
            if (idx_next == IDX_W'(k) && (active_next >> (4*k)) == '0) blank = 1'b1;
        end
`else
        blank = 1'b0;
`endif

        en_next  = (state_next == S_ON) && !blank;
        sel_next = en_next ? (DIGITS'(1) << idx_next) : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx       <= '0;
            active    <= '0;
            shadow    <= '0;
            pending   <= 1'b0;
            frame     <= 1'b0;
            D         <= '0;
            enable    <= 1'b0;
            digit_sel <= '0;
        end else begin
            idx       <= idx_next;
            active    <= active_next;
            shadow    <= shadow_next;
            pending   <= pending_next;
            frame     <= boundary;
            D         <= d_next;
            enable    <= en_next;
            digit_sel <= sel_next;
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: scoreboard bench for seg7_scan with DIGITS=4, PRESCALE=8,
// DEAD=2. The driver pushes the expected outputs of each cycle into a queue;
// a monitor on the falling edge pops and compares against the DUT.
module tb_seg7_scan;

    localparam int DIG = 4;
    localparam int P   = 8;
    localparam int DT  = 2;

    typedef struct packed {
        logic       pend;
        logic       frm;
        logic [3:0] d;
        logic       en;
        logic [3:0] sel;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [15:0] value;
    logic        load;
    logic        pending;
    logic        frame;
    logic [3:0]  D;
    logic        enable;
    logic [3:0]  digit_sel;

    exp_t q[$];
    int   tags[$];
    int   n_tests;
    int   n_fail;
    int   scen_id;

    seg7_scan #(
        .DIGITS   (DIG),
        .PRESCALE (P),
        .DEAD     (DT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .value     (value),
        .load      (load),
        .pending   (pending),
        .frame     (frame),
        .D         (D),
        .enable    (enable),
        .digit_sel (digit_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs for cycle c (since reset release) given the value on
    // display during that cycle and the expected pending flag.
    function automatic exp_t mk(input int c, input logic [15:0] act, input logic pend);
        exp_t e;
        int   slot;
        int   ph;
        logic blank;
        logic [15:0] a;
        slot  = (c / P) % DIG;
        ph    = c % P;
        blank = 1'b0;
        a     = act;
`ifdef SEG7_SCAN_LZB_EN
        if (slot > 0 && (a >> (4*slot)) == 16'h0) blank = 1'b1;
`endif
        e.pend = pend;
        e.frm  = (c > 0) && (c % (DIG*P) == 0);
        e.d    = a[4*slot +: 4];
        e.en   = (ph >= DT) && !blank;
        e.sel  = e.en ? 4'(1 << slot) : 4'h0;
        return e;
    endfunction

    task automatic do_reset();
        exp_t z;
        z = '0;
        @(posedge clk); #1;
        reset = 1'b1;
        load  = 1'b0;
        value = 16'h0;
        @(posedge clk); #1;
        q.push_back(z);
        tags.push_back(-1);
    endtask

    // One scenario: up to two loads, the value expected from frame 1 on, the
    // pending window [p_lo, p_hi], and an optional reset request at rst_at.
    task automatic scen(input int n, input bit pre_rst,
                        input int t1, input logic [15:0] v1,
                        input int t2, input logic [15:0] v2,
                        input logic [15:0] act_after,
                        input int p_lo, input int p_hi, input int rst_at);
        logic [15:0] act;
        if (pre_rst) do_reset();
        for (int c = 0; c < n; c++) begin
            if (c > 0 || !pre_rst) begin
                @(posedge clk); #1;
            end else begin
                @(posedge clk); #1;
            end
            reset = (c == rst_at);
            load  = (c == t1) || (c == t2);
            value = (c == t2) ? v2 : ((c == t1) ? v1 : 16'h0);
            act   = (c >= DIG*P) ? act_after : 16'h0;
            q.push_back(mk(c, act, (c >= p_lo) && (c <= p_hi)));
            tags.push_back(scen_id*1000 + c);
        end
    endtask

    initial begin : monitor
        exp_t e;
        exp_t got;
        int   tag;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e   = q.pop_front();
                tag = tags.pop_front();
                got = '{pend: pending, frm: frame, d: D, en: enable, sel: digit_sel};
                n_tests++;
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL cycle_check tag=%0d got pend=%b frame=%b D=%h en=%b sel=%b want pend=%b frame=%b D=%h en=%b sel=%b",
                             tag, got.pend, got.frm, got.d, got.en, got.sel,
                             e.pend, e.frm, e.d, e.en, e.sel);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin : driver
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        load    = 1'b0;
        value   = 16'h0;
        repeat (2) @(posedge clk);

        // Reset release and load 1234 at cycle 5: displayed from cycle 32.
        scen_id = 1;
        scen(64, 1'b1, 5, 16'h1234, -1, 16'h0, 16'h1234, 6, 31, -1);

        // Two loads in one frame: last wins, AAAA never shown.
        scen_id = 2;
        scen(64, 1'b1, 10, 16'hAAAA, 20, 16'h5555, 16'h5555, 11, 31, -1);

        // Load exactly on boundary cycle 31: bypasses shadow, no pending.
        scen_id = 3;
        scen(40, 1'b1, 31, 16'hBEEF, -1, 16'h0, 16'hBEEF, 1, 0, -1);

        // Pending value overridden by a boundary load.
        scen_id = 4;
        scen(48, 1'b1, 3, 16'h1111, 31, 16'h2222, 16'h2222, 4, 31, -1);

        // Mid-frame reset at cycle 45 with 1234 active, then a clean restart.
        scen_id = 5;
        scen(46, 1'b1, 5, 16'h1234, -1, 16'h0, 16'h1234, 6, 31, 45);
        scen_id = 6;
        scen(40, 1'b0, -1, 16'h0, -1, 16'h0, 16'h0, 1, 0, -1);

        // Value with leading zeros (blanked only when the feature is built in).
        scen_id = 7;
        scen(64, 1'b1, 3, 16'h0050, -1, 16'h0, 16'h0050, 4, 31, -1);

        @(posedge clk); #1;
        load = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: %0d entries left, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
